// File: rtl/tx_symbol_source.sv
// tx_symbol_source
//   TX symbol generator: symbol-rate strobe timing, one PRBS9 source per lane and a
//   QPSK / 16-QAM Gray mapper. Emits one mapped I/Q symbol every OS enabled clocks
//   for the polyphase shaping filter and exports the raw bits for the BER checker.
// Ports
//   i_clock      system clock
//   i_reset      synchronous, active-low reset
//   i_enable     run; low freezes all state (o_valid drops on the next edge)
//   i_mode       0 = QPSK, 1 = 16-QAM, sampled on the strobe cycle only
//   i_phase      counter value on which the strobe fires (ignored when OS == 1)
//   o_valid      one-cycle pulse, new symbol on the outputs
//   o_phase_cnt  symbol-phase counter, drives the filter phase mux
//   o_symbI/Q    mapped symbols, signed S(NB_OUTPUT, NBF_OUTPUT)
//   o_bitsI/Q    raw lane bits {b1, b0}; b0 is 0 in QPSK
//   o_sym_count  symbols emitted since reset, wrapping
module tx_symbol_source #(
  parameter int unsigned OS         = 4,
  parameter int unsigned NB_OUTPUT  = 8,
  parameter int unsigned NBF_OUTPUT = 7,
  parameter logic [8:0]  SEED_I     = 9'h1AA,
  parameter logic [8:0]  SEED_Q     = 9'h1FE,
  localparam int unsigned NBC       = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_mode,
  input  logic [NBC-1:0]              i_phase,
  output logic                        o_valid,
  output logic [NBC-1:0]              o_phase_cnt,
  output logic signed [NB_OUTPUT-1:0] o_symbI,
  output logic signed [NB_OUTPUT-1:0] o_symbQ,
  output logic [1:0]                  o_bitsI,
  output logic [1:0]                  o_bitsQ,
  output logic [31:0]                 o_sym_count
);

  // Unit level L = 2^(NBF_OUTPUT-2); all constellation points are exact multiples.
  localparam int Lvl = int'(2 ** (NBF_OUTPUT - 2));
  localparam logic [NB_OUTPUT-1:0] LvlP1 = NB_OUTPUT'(Lvl);
  localparam logic [NB_OUTPUT-1:0] LvlN1 = NB_OUTPUT'(-Lvl);
  localparam logic [NB_OUTPUT-1:0] LvlP2 = NB_OUTPUT'(2 * Lvl);
  localparam logic [NB_OUTPUT-1:0] LvlN2 = NB_OUTPUT'(-2 * Lvl);
  localparam logic [NB_OUTPUT-1:0] LvlP3 = NB_OUTPUT'(3 * Lvl);
  localparam logic [NB_OUTPUT-1:0] LvlN3 = NB_OUTPUT'(-3 * Lvl);

  // x^9 + x^5 + 1, output bit is lfsr[8] before the shift.
  function automatic logic [8:0] prbs_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  function automatic logic [NB_OUTPUT-1:0] map_level(input logic [1:0] b, input logic qam);
    logic [NB_OUTPUT-1:0] lvl;
    lvl = '0;
    if (!qam) begin
      lvl = b[1] ? LvlN2 : LvlP2;
    end else begin
      // Gray order along the axis: 10, 11, 01, 00 from -3L to +3L.
      unique case (b)
        2'b00: lvl = LvlP3;
        2'b01: lvl = LvlP1;
        2'b11: lvl = LvlN1;
        2'b10: lvl = LvlN3;
        default: lvl = '0;
      endcase
    end
    return lvl;
  endfunction

  logic [NBC-1:0]       r_cnt;
  logic [8:0]           r_lfsr_i;
  logic [8:0]           r_lfsr_q;
  logic                 r_valid;
  logic [NB_OUTPUT-1:0] r_symb_i;
  logic [NB_OUTPUT-1:0] r_symb_q;
  logic [1:0]           r_bits_i;
  logic [1:0]           r_bits_q;
  logic [31:0]          r_sym_count;

  logic                 w_strobe;
  logic [NBC-1:0]       w_cnt_next;
  logic [8:0]           w_lfsr_i_next;
  logic [8:0]           w_lfsr_q_next;
  logic [1:0]           w_bits_i;
  logic [1:0]           w_bits_q;
  logic [NB_OUTPUT-1:0] w_symb_i;
  logic [NB_OUTPUT-1:0] w_symb_q;

  always_comb begin
    w_strobe   = i_enable;
    w_cnt_next = '0;
    if (OS > 1) begin
      w_strobe = i_enable && (r_cnt == i_phase);
      // Compare against OS-1 rather than relying on natural overflow so that
      // non-power-of-two OS wraps correctly.
      w_cnt_next = (r_cnt == NBC'(OS - 1)) ? '0 : r_cnt + NBC'(1);
    end
  end

  always_comb begin
    w_bits_i      = {r_lfsr_i[8], 1'b0};
    w_bits_q      = {r_lfsr_q[8], 1'b0};
    w_lfsr_i_next = prbs_step(r_lfsr_i);
    w_lfsr_q_next = prbs_step(r_lfsr_q);
    if (i_mode) begin
      // Two shifts per symbol; the second output bit is lfsr[7] of the current state.
      w_bits_i      = r_lfsr_i[8:7];
      w_bits_q      = r_lfsr_q[8:7];
      w_lfsr_i_next = prbs_step(prbs_step(r_lfsr_i));
      w_lfsr_q_next = prbs_step(prbs_step(r_lfsr_q));
    end
    w_symb_i = map_level(w_bits_i, i_mode);
    w_symb_q = map_level(w_bits_q, i_mode);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cnt       <= '0;
      r_lfsr_i    <= SEED_I;
      r_lfsr_q    <= SEED_Q;
      r_valid     <= 1'b0;
      r_symb_i    <= '0;
      r_symb_q    <= '0;
      r_bits_i    <= '0;
      r_bits_q    <= '0;
      r_sym_count <= '0;
    end else if (i_enable) begin
      r_cnt   <= w_cnt_next;
      r_valid <= w_strobe;
      if (w_strobe) begin
        r_lfsr_i    <= w_lfsr_i_next;
        r_lfsr_q    <= w_lfsr_q_next;
        r_symb_i    <= w_symb_i;
        r_symb_q    <= w_symb_q;
        r_bits_i    <= w_bits_i;
        r_bits_q    <= w_bits_q;
        r_sym_count <= r_sym_count + 32'd1;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_phase_cnt = r_cnt;
  assign o_symbI     = r_symb_i;
  assign o_symbQ     = r_symb_q;
  assign o_bitsI     = r_bits_i;
  assign o_bitsQ     = r_bits_q;
  assign o_sym_count = r_sym_count;

endmodule
